mc_ctrl_fsm: RTL and testbench



---
 rtl/mc_pkg.sv | 88 ++++++++
 rtl/mc_alu_dec.sv | 33 +++
 rtl/mc_ctrl_fsm.sv | 235 +++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control sequencer.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_TRAP = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        CL_R      = 4'd0,
        CL_I      = 4'd1,
        CL_LOAD   = 4'd2,
        CL_STORE  = 4'd3,
        CL_LUI    = 4'd4,
        CL_AUIPC  = 4'd5,
        CL_BRANCH = 4'd6,
        CL_JAL    = 4'd7,
        CL_JALR   = 4'd8,
        CL_SYSTEM = 4'd9,
        CL_ILL    = 4'd10
    } class_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_PRIV = 3'b000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [2:0] WD_ALU   = 3'd0;
    localparam logic [2:0] WD_IMM   = 3'd1;
    localparam logic [2:0] WD_MDR   = 3'd2;
    localparam logic [2:0] WD_PC4   = 3'd3;
    localparam logic [2:0] WD_PCIMM = 3'd4;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_PC0IMM = 2'd1;
    localparam logic [1:0] PC_ALU    = 2'd2;

    localparam logic [1:0] TC_NONE    = 2'd0;
    localparam logic [1:0] TC_ILLEGAL = 2'd1;
    localparam logic [1:0] TC_IMEM_TO = 2'd2;
    localparam logic [1:0] TC_DMEM_TO = 2'd3;

    // Map a raw opcode onto an instruction class; unknown opcodes are illegal.
    function automatic class_e classify(input logic [6:0] op);
        class_e cls;
        case (op)
            OP_R:      cls = CL_R;
            OP_I:      cls = CL_I;
            OP_LOAD:   cls = CL_LOAD;
            OP_STORE:  cls = CL_STORE;
            OP_LUI:    cls = CL_LUI;
            OP_AUIPC:  cls = CL_AUIPC;
            OP_BRANCH: cls = CL_BRANCH;
            OP_JAL:    cls = CL_JAL;
            OP_JALR:   cls = CL_JALR;
            OP_SYSTEM: cls = CL_SYSTEM;
            default:   cls = CL_ILL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// Combinational ALU function decode from instruction class and funct fields.
module mc_alu_dec
    import mc_pkg::*;
(
    input  class_e      cls,
    input  logic [2:0]  funct3,
    input  logic        funct7_b5,
    output logic [3:0]  alu_op
);

    // funct7[5] picks SUB only for register ops; it picks SRA for both forms
    always_comb begin
        alu_op = ALU_ADD;
        case (cls)
            CL_R, CL_I: begin
                case (funct3)
                    3'b000:  alu_op = ((cls == CL_R) && funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    3'b111:  alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            CL_BRANCH: alu_op = ALU_SUB;
            default:   alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32 control sequencer with memory handshakes, timeouts,
// illegal-instruction trap, halt and retired-instruction counter.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int ALU_OP_W = 4,
    parameter int TIMEOUT  = 16,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                zf,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                mem_write,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc0_write,
    output logic                reg_write,
    output logic [1:0]          pc_s,
    output logic                rs2_imm_s,
    output logic [2:0]          w_data_s,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                halted,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [CNT_W-1:0]    retired
);

    state_e           state_r, state_s;
    class_e           cls_s;
    logic [7:0]       wait_r, wait_inc_s;
    logic             timeout_s, taken_s, br_second_r;
    logic [3:0]       alu_dec_s, alu_op_s;
    logic             imem_req_s, dmem_req_s, mem_write_s, ir_write_s;
    logic             pc_write_s, pc0_write_s, reg_write_s, rs2_sel_s;
    logic [1:0]       pc_sel_s, cause_s;
    logic [2:0]       wd_sel_s;
    logic             halted_r, trap_r;
    logic [1:0]       cause_r;
    logic [CNT_W-1:0] retired_r;
    logic             funct7_unused_s;

    assign cls_s           = classify(opcode);
    assign wait_inc_s      = wait_r + 8'd1;
    // An ack in the same cycle the count hits TIMEOUT wins over the timeout
    assign timeout_s       = (wait_inc_s == 8'(TIMEOUT));
    assign taken_s         = (funct3 == F3_BEQ) ? zf : ~zf;
    assign funct7_unused_s = ^{funct7[6], funct7[4:0]};

    mc_alu_dec u_alu_dec (
        .cls       (cls_s),
        .funct3    (funct3),
        .funct7_b5 (funct7[5]),
        .alu_op    (alu_dec_s)
    );

    // Next-state and datapath strobe decode; acks are only looked at in IF/MEM
    always_comb begin
        state_s     = state_r;
        imem_req_s  = 1'b0;
        dmem_req_s  = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        pc0_write_s = 1'b0;
        reg_write_s = 1'b0;
        rs2_sel_s   = 1'b0;
        pc_sel_s    = PC_PLUS4;
        wd_sel_s    = WD_ALU;
        alu_op_s    = ALU_ADD;
        cause_s     = TC_NONE;
        case (state_r)
            S_IF: begin
                imem_req_s = 1'b1;
                if (imem_ack) begin
                    ir_write_s  = 1'b1;
                    pc0_write_s = 1'b1;
                    state_s     = S_ID;
                end else if (timeout_s) begin
                    state_s = S_TRAP;
                    cause_s = TC_IMEM_TO;
                end else begin
                    state_s = S_IF;
                end
            end
            S_ID: begin
                case (cls_s)
                    CL_SYSTEM: begin
                        if (funct3 == F3_PRIV) begin
                            state_s = S_HALT;
                        end else begin
                            state_s = S_TRAP;
                            cause_s = TC_ILLEGAL;
                        end
                    end
                    CL_BRANCH: begin
                        if ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) begin
                            state_s = S_EX;
                        end else begin
                            state_s = S_TRAP;
                            cause_s = TC_ILLEGAL;
                        end
                    end
                    CL_ILL: begin
                        state_s = S_TRAP;
                        cause_s = TC_ILLEGAL;
                    end
                    default: state_s = S_EX;
                endcase
            end
            S_EX: begin
                alu_op_s  = alu_dec_s;
                rs2_sel_s = (cls_s != CL_R) && (cls_s != CL_BRANCH);
                case (cls_s)
                    CL_LOAD, CL_STORE: state_s = S_MEM;
                    CL_BRANCH: begin
                        // zf for the SUB issued in the first EX cycle is valid in the second
                        if (br_second_r) begin
                            pc_write_s = 1'b1;
                            pc_sel_s   = taken_s ? PC_PC0IMM : PC_PLUS4;
                            state_s    = S_IF;
                        end else begin
                            state_s = S_EX;
                        end
                    end
                    default: state_s = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req_s  = 1'b1;
                mem_write_s = (cls_s == CL_STORE);
                if (dmem_ack) begin
                    if (cls_s == CL_STORE) begin
                        pc_write_s = 1'b1;
                        pc_sel_s   = PC_PLUS4;
                        state_s    = S_IF;
                    end else begin
                        state_s = S_WB;
                    end
                end else if (timeout_s) begin
                    state_s = S_TRAP;
                    cause_s = TC_DMEM_TO;
                end else begin
                    state_s = S_MEM;
                end
            end
            S_WB: begin
                reg_write_s = 1'b1;
                pc_write_s  = 1'b1;
                state_s     = S_IF;
                case (cls_s)
                    CL_LUI:   wd_sel_s = WD_IMM;
                    CL_LOAD:  wd_sel_s = WD_MDR;
                    CL_AUIPC: wd_sel_s = WD_PCIMM;
                    CL_JAL: begin
                        wd_sel_s = WD_PC4;
                        pc_sel_s = PC_PC0IMM;
                    end
                    CL_JALR: begin
                        wd_sel_s = WD_PC4;
                        pc_sel_s = PC_ALU;
                    end
                    default:  wd_sel_s = WD_ALU;
                endcase
            end
            S_HALT:  state_s = S_HALT;
            S_TRAP:  state_s = S_TRAP;
            default: state_s = S_IF;
        endcase
    end

    // State register, per-access wait counter and branch second-cycle flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IF;
            wait_r      <= 8'd0;
            br_second_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            wait_r      <= ((state_s == state_r) && ((state_r == S_IF) || (state_r == S_MEM)))
                           ? wait_inc_s : 8'd0;
            br_second_r <= (state_r == S_EX) && (state_s == S_EX);
        end
    end

    // Sticky halt/trap flags, latched on entry to the absorbing states
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r <= 1'b0;
            trap_r   <= 1'b0;
            cause_r  <= TC_NONE;
        end else begin
            if ((state_s == S_HALT) && (state_r != S_HALT)) begin
                halted_r <= 1'b1;
            end
            if ((state_s == S_TRAP) && (state_r != S_TRAP)) begin
                trap_r  <= 1'b1;
                cause_r <= cause_s;
            end
        end
    end

    // Retired counter: one per completed instruction, free-running wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_r <= {CNT_W{1'b0}};
        end else if (pc_write_s) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Strobes are forced low while rst is held so an aborted access writes nothing
    assign imem_req   = imem_req_s  & ~rst;
    assign dmem_req   = dmem_req_s  & ~rst;
    assign mem_write  = mem_write_s & ~rst;
    assign ir_write   = ir_write_s  & ~rst;
    assign pc_write   = pc_write_s  & ~rst;
    assign pc0_write  = pc0_write_s & ~rst;
    assign reg_write  = reg_write_s & ~rst;
    assign rs2_imm_s  = rs2_sel_s   & ~rst;
    assign pc_s       = rst ? 2'd0 : pc_sel_s;
    assign w_data_s   = rst ? 3'd0 : wd_sel_s;
    assign alu_op     = rst ? {ALU_OP_W{1'b0}} : ALU_OP_W'(alu_op_s);
    assign halted     = halted_r;
    assign trap       = trap_r;
    assign trap_cause = cause_r;
    assign retired    = retired_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed self-checking bench for mc_ctrl_fsm.
module tb_mc_ctrl_fsm;

    logic        clk, rst, zf, imem_ack, dmem_ack;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        imem_req, dmem_req, mem_write, ir_write, pc_write, pc0_write, reg_write;
    logic [1:0]  pc_s;
    logic        rs2_imm_s;
    logic [2:0]  w_data_s;
    logic [3:0]  alu_op;
    logic        halted, trap;
    logic [1:0]  trap_cause;
    logic [31:0] retired;
    logic [16:0] obs_s;

    int n_pass   = 0;
    int n_fail   = 0;
    int n_checks = 0;
    int exp_ret  = 0;

    mc_ctrl_fsm #(.ALU_OP_W(4), .TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zf(zf), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .pc0_write(pc0_write),
        .reg_write(reg_write), .pc_s(pc_s), .rs2_imm_s(rs2_imm_s),
        .w_data_s(w_data_s), .alu_op(alu_op), .halted(halted), .trap(trap),
        .trap_cause(trap_cause), .retired(retired)
    );

    assign obs_s = {imem_req, dmem_req, mem_write, ir_write, pc_write, pc0_write,
                    reg_write, pc_s, rs2_imm_s, w_data_s, alu_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected strobe bundle, same field order as obs_s
    function automatic logic [16:0] ev(input logic imem, input logic dmem, input logic mw,
                                       input logic irw, input logic pcw, input logic pc0w,
                                       input logic rw, input logic [1:0] pcs, input logic rs2,
                                       input logic [2:0] wds, input logic [3:0] alu);
        return {imem, dmem, mw, irw, pcw, pc0w, rw, pcs, rs2, wds, alu};
    endfunction

    localparam logic [16:0] V_ZERO   = 17'd0;
    localparam logic [16:0] V_IF     = 17'h10000;
    localparam logic [16:0] V_IF_ACK = 17'h12800;
    localparam logic [16:0] V_MEM_RD = 17'h08000;
    localparam logic [16:0] V_EX_IMM = 17'h00080;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs set: check strobes, then advance one cycle
    task automatic step(input string tag, input logic [16:0] exp);
        #1;
        chk(tag, 32'(obs_s), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int idle);
        for (int i = 0; i < idle; i++) begin
            imem_ack = 1'b0;
            step("if_wait", V_IF);
        end
        imem_ack = 1'b1;
        step("if_ack", V_IF_ACK);
        imem_ack = 1'b0;
    endtask

    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input int idle,
                             input logic [16:0] exp_ex, input logic [16:0] exp_wb);
        opcode = op; funct3 = f3; funct7 = f7;
        fetch(idle);
        step({tag, "_id"}, V_ZERO);
        step({tag, "_ex"}, exp_ex);
        step({tag, "_wb"}, exp_wb);
        exp_ret++;
        chk({tag, "_retired"}, retired, 32'(exp_ret));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step("reset_strobes", V_ZERO);
        rst = 1'b0;
        exp_ret = 0;
    endtask

    initial begin
        rst = 1'b1; zf = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
        @(posedge clk);
        #1;
        step("reset_strobes", V_ZERO);
        chk("reset_status", {halted, trap, trap_cause}, 32'd0);
        chk("reset_retired", retired, 32'd0);
        rst = 1'b0;

        // ADDI with the instruction ack three cycles late
        run_instr("addi", 7'b0010011, 3'b000, 7'b0000000, 3, V_EX_IMM,
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 4'd0));

        // LW, data ack on second MEM cycle
        opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'd0;
        fetch(0);
        step("lw_id", V_ZERO);
        step("lw_ex", V_EX_IMM);
        step("lw_mem1", V_MEM_RD);
        dmem_ack = 1'b1;
        step("lw_mem2", V_MEM_RD);
        dmem_ack = 1'b0;
        step("lw_wb", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 3'd2, 4'd0));
        exp_ret++;
        chk("lw_retired", retired, 32'(exp_ret));

        // SW, a stray imem_ack during MEM must be ignored
        opcode = 7'b0100011;
        fetch(0);
        step("sw_id", V_ZERO);
        step("sw_ex", V_EX_IMM);
        imem_ack = 1'b1;
        step("sw_mem_stray", ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 4'd0));
        imem_ack = 1'b0; dmem_ack = 1'b1;
        step("sw_mem_ack", ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 4'd0));
        dmem_ack = 1'b0;
        exp_ret++;
        chk("sw_retired", retired, 32'(exp_ret));

        // BEQ taken then not taken
        for (int k = 0; k < 2; k++) begin
            opcode = 7'b1100011; funct3 = 3'b000; zf = 1'b0;
            fetch(0);
            step("beq_id", V_ZERO);
            step("beq_ex1", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 4'd1));
            zf = (k == 0);
            step("beq_ex2", ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                               (k == 0) ? 2'd1 : 2'd0, 1'b0, 3'd0, 4'd1));
            zf = 1'b0;
            exp_ret++;
            chk("beq_retired", retired, 32'(exp_ret));
        end

        run_instr("jalr", 7'b1100111, 3'b000, 7'b0000000, 0, V_EX_IMM,
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 3'd3, 4'd0));
        run_instr("sub", 7'b0110011, 3'b000, 7'b0100000, 0,
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 4'd1),
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 4'd0));
        run_instr("srai", 7'b0010011, 3'b101, 7'b0100000, 0,
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd0, 4'd7),
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 4'd0));
        run_instr("addi_f7", 7'b0010011, 3'b000, 7'b0100000, 0, V_EX_IMM,
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 4'd0));
        run_instr("andr", 7'b0110011, 3'b111, 7'b0000000, 0,
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 4'd2),
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 4'd0));
        run_instr("lui", 7'b0110111, 3'b000, 7'b0000000, 0, V_EX_IMM,
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 3'd1, 4'd0));
        run_instr("auipc", 7'b0010111, 3'b000, 7'b0000000, 0, V_EX_IMM,
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 3'd4, 4'd0));
        run_instr("jal", 7'b1101111, 3'b000, 7'b0000000, 0, V_EX_IMM,
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 3'd3, 4'd0));
        // Ack on the 16th waiting cycle still counts as a normal fetch
        run_instr("ack_at_16", 7'b0010011, 3'b000, 7'b0000000, 15, V_EX_IMM,
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 4'd0));
        chk("no_trap_yet", {halted, trap, trap_cause}, 32'd0);

        // Illegal opcode traps, retired unchanged, acks ignored afterwards
        opcode = 7'b0000000; funct3 = 3'b000;
        fetch(0);
        step("ill_id", V_ZERO);
        chk("ill_trap", {halted, trap, trap_cause}, 32'b0101);
        chk("ill_retired", retired, 32'(exp_ret));
        imem_ack = 1'b1; dmem_ack = 1'b1;
        step("trap_absorb", V_ZERO);
        imem_ack = 1'b0; dmem_ack = 1'b0;
        chk("trap_retired", retired, 32'(exp_ret));

        // Instruction fetch timeout
        do_reset();
        chk("rst_clears_trap", {halted, trap, trap_cause, retired[3:0]}, 32'd0);
        for (int i = 0; i < 16; i++) step("if_timeout_wait", V_IF);
        chk("imem_timeout", {halted, trap, trap_cause}, 32'b0110);
        step("imem_trap_idle", V_ZERO);

        // Unsupported branch funct3 traps as illegal
        do_reset();
        opcode = 7'b1100011; funct3 = 3'b100;
        fetch(0);
        step("blt_id", V_ZERO);
        chk("blt_trap", {halted, trap, trap_cause}, 32'b0101);

        // ECALL halts after one retired instruction
        do_reset();
        run_instr("pre_halt", 7'b0010011, 3'b000, 7'b0000000, 0, V_EX_IMM,
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 4'd0));
        opcode = 7'b1110011; funct3 = 3'b000;
        fetch(0);
        step("ecall_id", V_ZERO);
        chk("ecall_halted", {halted, trap, trap_cause}, 32'b1000);
        imem_ack = 1'b1;
        step("halt_absorb1", V_ZERO);
        imem_ack = 1'b0; dmem_ack = 1'b1;
        step("halt_absorb2", V_ZERO);
        dmem_ack = 1'b0;
        chk("halt_retired", retired, 32'd1);

        // Data access timeout
        do_reset();
        opcode = 7'b0000011; funct3 = 3'b010;
        fetch(0);
        step("lwto_id", V_ZERO);
        step("lwto_ex", V_EX_IMM);
        for (int i = 0; i < 16; i++) step("mem_timeout_wait", V_MEM_RD);
        chk("dmem_timeout", {halted, trap, trap_cause}, 32'b0111);

        // Reset in the middle of MEM aborts with no writes
        do_reset();
        run_instr("pre_abort", 7'b0010011, 3'b000, 7'b0000000, 0, V_EX_IMM,
                  ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0, 4'd0));
        opcode = 7'b0100011; funct3 = 3'b010;
        fetch(0);
        step("abort_id", V_ZERO);
        step("abort_ex", V_EX_IMM);
        step("abort_mem1", ev(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 4'd0));
        rst = 1'b1; dmem_ack = 1'b1;
        step("abort_rst_cycle", V_ZERO);
        dmem_ack = 1'b0;
        #1;
        chk("abort_outputs", 32'(obs_s), 32'd0);
        chk("abort_retired", retired, 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_then_if", 32'(obs_s), 32'(V_IF));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
